// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, opcode constants and FSM state type for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int PC_W     = 3;
  localparam int INSTR_W  = 12;
  localparam int OPCODE_W = 3;
  localparam int CNT_W    = 8;

  localparam logic [OPCODE_W-1:0] HALT_OP = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } fetch_state_t;

  function automatic logic isHaltOp(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM address/data and datapath issue handshake bundle between the sequencer and its neighbours.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] rom_instr;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               exec_ready;
  logic               jump_valid;
  logic [PC_W-1:0]    jump_target;

  modport master (
    output pc, instr, instr_valid,
    input  rom_instr, exec_ready, jump_valid, jump_target
  );

  modport slave (
    input  pc, instr, instr_valid,
    output rom_instr, exec_ready, jump_valid, jump_target
  );

endinterface

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter: advances on each accepted instruction, loads a jump target, clears on restart.
module pc_counter
  import fetch_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_restart,
  input  logic            i_advance,
  input  logic            i_jump,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // Restart outranks an accept in the same cycle; the increment wraps naturally at 2**PC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_restart) begin
      r_pc <= '0;
    end else if (i_advance) begin
      r_pc <= i_jump ? i_target : r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer for the 8-entry instruction ROM: run, single-step, jumps and HALT.
// Optional feature: define BREAKPOINT_EN to add a free-run address breakpoint (bp_en_i/bp_addr_i).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             restart_i,
`ifdef BREAKPOINT_EN
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
`endif
  fetch_sequencer_if.master bus,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
);

  fetch_state_t       r_state;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_halted;
  logic [CNT_W-1:0]   r_retired;

  logic [PC_W-1:0]    w_pc;
  logic               w_accept;
  logic               w_bpHit;

  assign w_accept = (r_state == ISSUE) && r_valid && bus.exec_ready;

  pc_counter u_pcCounter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (restart_i),
    .i_advance (w_accept),
    .i_jump    (bus.jump_valid),
    .i_target  (bus.jump_target),
    .o_pc      (w_pc)
  );

`ifdef BREAKPOINT_EN
  logic r_stepEntry;

  // Remembers whether FETCH was entered by a step, so stepping can move past a breakpoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stepEntry <= 1'b0;
    end else if (r_state == IDLE && (run_i || step_i)) begin
      r_stepEntry <= step_i;
    end else if (w_accept) begin
      r_stepEntry <= 1'b0;
    end
  end

  assign w_bpHit = run_i && !r_stepEntry && bp_en_i && (w_pc == bp_addr_i);
`else
  assign w_bpHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else if (restart_i) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run_i || step_i) begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (w_bpHit) begin
            r_state <= IDLE;
          end else begin
            r_instr <= bus.rom_instr;
            if (isHaltOp(bus.rom_instr)) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state <= ISSUE;
              r_valid <= 1'b1;
            end
          end
        end
        // Dropping run mid-instruction still lets the pending word retire before idling.
        ISSUE: begin
          if (w_accept) begin
            r_retired <= r_retired + CNT_W'(1);
            r_valid   <= 1'b0;
            r_state   <= run_i ? FETCH : IDLE;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pc          = w_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign halted_o        = r_halted;
  assign retired_o       = r_retired;

endmodule
